str_restrict: RTL and testbench

- AXI-Stream-style gear box that converts a stream of DATA_UP_WIDTH words into a stream of DATA_DN_WIDTH words.
- Behaviour depends on the width ratio:
  - equal widths: registered pass-through;
  - wider input: serialises each input word into several output words, lowest slice first;
  - narrower input: packs several input words into one output word, slot 0 first.
- One register stage deep; sits between stream producers and consumers of different bus widths in the datapath.

---
 rtl/str_restrict.sv | 100 ++++++++++
 tb/tb_str_restrict.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/str_restrict.sv
// str_restrict: stream width gearbox (pass-through, serialise or deserialise) with one register stage.
// Ratio is chosen at elaboration; a low dn_rdy freezes every register.
module str_restrict #(
  parameter int DATA_UP_WIDTH = 2,
  parameter int DATA_DN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_UP_WIDTH-1:0] up_data,
  input  logic                     up_last,
  input  logic                     up_val,
  output logic                     up_rdy,
  output logic [DATA_DN_WIDTH-1:0] dn_data,
  output logic                     dn_last,
  output logic                     dn_val,
  input  logic                     dn_rdy
);
  localparam int UP = DATA_UP_WIDTH;
  localparam int DN = DATA_DN_WIDTH;
  logic vld, lst;
  assign dn_val  = vld & dn_rdy;
  assign dn_last = lst & dn_rdy;
  if (UP == DN) begin : g_pass
    logic          val_q, last_q;
    logic [DN-1:0] data_q;
    assign up_rdy  = dn_rdy;
    assign dn_data = data_q;
    assign vld     = val_q;
    assign lst     = last_q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        val_q  <= 1'b0;
        last_q <= 1'b0;
        data_q <= '0;
      end else if (dn_rdy) begin
        val_q  <= up_val;
        last_q <= up_val & up_last;
        if (up_val) data_q <= up_data;
      end
  end else if (UP > DN) begin : g_ser
    localparam int NB = UP / DN;
    logic          acc;
    logic [NB-1:0] tok_q, tok_d, vv_q, vv_d, lv_q, lv_d;
    logic [UP-1:0] sh_q, sh_d;
    assign up_rdy  = dn_rdy & tok_q[0];
    assign acc     = up_val & up_rdy;
    assign dn_data = sh_q[DN-1:0];
    assign vld     = vv_q[0];
    assign lst     = lv_q[0];
    // token sits on bit 0 only while waiting for a new word
    always_comb begin
      tok_d = (!tok_q[0] || acc) ? {tok_q[NB-2:0], tok_q[NB-1]} : tok_q;
      sh_d  = acc ? up_data : sh_q >> DN;
      vv_d  = acc ? '1 : vv_q >> 1;
      lv_d  = acc ? {up_last, {(NB-1){1'b0}}} : lv_q >> 1;
    end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        tok_q <= NB'(1);
        sh_q  <= '0;
        vv_q  <= '0;
        lv_q  <= '0;
      end else if (dn_rdy) begin
        tok_q <= tok_d;
        sh_q  <= sh_d;
        vv_q  <= vv_d;
        lv_q  <= lv_d;
      end
  end else begin : g_des
    localparam int NB = DN / UP;
    logic          acc, val_q, val_d, last_q, last_d;
    logic [NB-1:0] tok_q, tok_d;
    logic [DN-1:0] sh_q, sh_d;
    assign up_rdy  = dn_rdy;
    assign acc     = up_val & up_rdy;
    assign dn_data = sh_q;
    assign vld     = val_q;
    assign lst     = last_q;
    // slot write ignores up_val; dn_val only fires on a completed word
    always_comb begin
      sh_d = sh_q;
      for (int i = 0; i < NB; i++) if (tok_q[i]) sh_d[i*UP +: UP] = up_data;
      tok_d  = !acc ? tok_q : up_last ? NB'(1) : {tok_q[NB-2:0], tok_q[NB-1]};
      val_d  = up_val & (tok_q[NB-1] | up_last);
      last_d = up_val & up_last;
    end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        tok_q  <= NB'(1);
        sh_q   <= '0;
        val_q  <= 1'b0;
        last_q <= 1'b0;
      end else if (dn_rdy) begin
        tok_q  <= tok_d;
        sh_q   <= sh_d;
        val_q  <= val_d;
        last_q <= last_d;
      end
  end
endmodule

// File: tb/tb_str_restrict.sv
// tb_str_restrict: scoreboard bench for the pass (8/8), serialise (8/2) and deserialise (2/8) gearboxes.
module tb_str_restrict;
  typedef struct packed {logic [7:0] d; logic [7:0] m; logic l;} exp_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [7:0] p_ud = 0, p_dd; logic p_ul = 0, p_uv = 0, p_ur, p_dl, p_dv, p_dr = 1;
  logic [7:0] s_ud = 0; logic [1:0] s_dd; logic s_ul = 0, s_uv = 0, s_ur, s_dl, s_dv, s_dr = 1;
  logic [1:0] d_ud = 0; logic [7:0] d_dd; logic d_ul = 0, d_uv = 0, d_ur, d_dl, d_dv, d_dr = 1;
  exp_t qp[$], qs[$], qd[$];
  int n_chk = 0, n_pass = 0;
  logic mon_en = 0, rnd = 0, stall = 0;
  logic [7:0] dacc = 0; int dfill = 0;

  str_restrict #(.DATA_UP_WIDTH(8), .DATA_DN_WIDTH(8)) u_p (.clk(clk), .rst(rst),
    .up_data(p_ud), .up_last(p_ul), .up_val(p_uv), .up_rdy(p_ur),
    .dn_data(p_dd), .dn_last(p_dl), .dn_val(p_dv), .dn_rdy(p_dr));
  str_restrict #(.DATA_UP_WIDTH(8), .DATA_DN_WIDTH(2)) u_s (.clk(clk), .rst(rst),
    .up_data(s_ud), .up_last(s_ul), .up_val(s_uv), .up_rdy(s_ur),
    .dn_data(s_dd), .dn_last(s_dl), .dn_val(s_dv), .dn_rdy(s_dr));
  str_restrict #(.DATA_UP_WIDTH(2), .DATA_DN_WIDTH(8)) u_d (.clk(clk), .rst(rst),
    .up_data(d_ud), .up_last(d_ul), .up_val(d_uv), .up_rdy(d_ur),
    .dn_data(d_dd), .dn_last(d_dl), .dn_val(d_dv), .dn_rdy(d_dr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [7:0] d, input logic l);
    chk({nm, "_data"}, d & e.m, e.d & e.m);
    chk({nm, "_last"}, l, e.l);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (p_dv) begin
      if (qp.size() == 0) begin n_chk++; $display("FAIL p_extra: got beat %0h want none", p_dd); end
      else cmp("p", qp.pop_front(), p_dd, p_dl);
    end
    if (s_dv) begin
      if (qs.size() == 0) begin n_chk++; $display("FAIL s_extra: got beat %0h want none", s_dd); end
      else cmp("s", qs.pop_front(), {6'b0, s_dd}, s_dl);
    end
    if (d_dv) begin
      if (qd.size() == 0) begin n_chk++; $display("FAIL d_extra: got beat %0h want none", d_dd); end
      else cmp("d", qd.pop_front(), d_dd, d_dl);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    p_dr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_dr = rnd ? ($urandom_range(0, 3) != 0) : !stall;
    d_dr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic wait_rdy(input int k);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if ((k == 0 && p_ur) || (k == 1 && s_ur) || (k == 2 && d_ur)) return;
    end
    n_chk++;
    $display("FAIL rdy_timeout: got up_rdy 0 for 1000 cycles on dut %0d want 1", k);
  endtask

  task automatic send_p(input logic [7:0] d, input logic l, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    p_ud = d; p_ul = l; p_uv = 1;
    wait_rdy(0);
    @(posedge clk); #1; p_uv = 0;
  endtask

  task automatic send_s(input logic [7:0] d, input logic l, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    s_ud = d; s_ul = l; s_uv = 1;
    wait_rdy(1);
    @(posedge clk); #1; s_uv = 0;
  endtask

  task automatic send_d(input logic [1:0] d, input logic l, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    d_ud = d; d_ul = l; d_uv = 1;
    wait_rdy(2);
    @(posedge clk); #1; d_uv = 0;
  endtask

  task automatic rnd_p();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] x; logic l;
      x = 8'($urandom); l = (k == 39) || ($urandom_range(0, 4) == 0);
      qp.push_back('{x, 8'hff, l});
      send_p(x, l, $urandom_range(0, 2));
    end
  endtask

  task automatic rnd_s();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] x; logic l;
      x = 8'($urandom); l = (k == 39) || ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++) qs.push_back('{8'((x >> (2 * i)) & 8'h3), 8'h03, l && i == 3});
      send_s(x, l, $urandom_range(0, 2));
    end
  endtask

  task automatic rnd_d();
    for (int k = 0; k < 60; k++) begin
      logic [1:0] x; logic l;
      x = 2'($urandom); l = (k == 59) || ($urandom_range(0, 5) == 0);
      dacc[2*dfill +: 2] = x;
      dfill++;
      if (dfill == 4 || l) begin
        qd.push_back('{dacc, 8'((16'd1 << (2 * dfill)) - 1), l});
        dfill = 0;
      end
      send_d(x, l, $urandom_range(0, 2));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_p_val", p_dv, 0); chk("rst_s_val", s_dv, 0); chk("rst_d_val", d_dv, 0);
    chk("rst_s_rdy", s_ur, 1);
    @(posedge clk); #1;
    // put traffic in flight, then reset in the middle of it
    p_ud = 8'hAA; p_uv = 1; s_ud = 8'hFF; s_uv = 1; d_ud = 2'd3; d_uv = 1;
    @(posedge clk); #1;
    p_uv = 0; s_uv = 0; d_uv = 0;
    chk("busy_s_val", s_dv, 1); chk("busy_p_val", p_dv, 1);
    rst = 0;
    #1;
    chk("arst_p_val", p_dv, 0); chk("arst_s_val", s_dv, 0); chk("arst_d_val", d_dv, 0);
    chk("arst_s_last", s_dl, 0); chk("arst_p_data", p_dd, 0); chk("arst_s_data", s_dd, 0);
    chk("arst_d_data", d_dd, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rel_p_val", p_dv, 0); chk("rel_d_last", d_dl, 0); chk("rel_d_data", d_dd, 0);
    chk("rel_s_rdy", s_ur, 1);
    @(posedge clk); #1;
    mon_en = 1;
    // pass-through
    qp.push_back('{8'h11, 8'hff, 1'b0}); qp.push_back('{8'h22, 8'hff, 1'b1});
    send_p(8'h11, 0, 0);
    chk("p_lat_data", p_dd, 8'h11);
    send_p(8'h22, 1, 0);
    chk("p_lat_last", p_dl, 1);
    // serialise one word
    qs.push_back('{8'd0, 8'h03, 1'b0}); qs.push_back('{8'd1, 8'h03, 1'b0});
    qs.push_back('{8'd2, 8'h03, 1'b0}); qs.push_back('{8'd3, 8'h03, 1'b1});
    send_s(8'hE4, 1, 0);
    for (int i = 0; i < 3; i++) begin chk("s_busy_rdy", s_ur, 0); @(posedge clk); #1; end
    chk("s_free_rdy", s_ur, 1);
    // deserialise: full word, partial word with last, then a word proving slot 0 restart
    qd.push_back('{8'h1B, 8'hff, 1'b0}); qd.push_back('{8'h09, 8'h0f, 1'b1});
    qd.push_back('{8'hE4, 8'hff, 1'b1});
    send_d(3, 0, 0); send_d(2, 0, 0); send_d(1, 0, 0); send_d(0, 0, 0);
    send_d(1, 0, 0); send_d(2, 1, 0);
    send_d(0, 0, 0); send_d(1, 0, 0); send_d(2, 0, 0); send_d(3, 1, 0);
    // serialise burst with a 3-cycle stall in the middle
    qs.push_back('{8'd3, 8'h03, 1'b0}); qs.push_back('{8'd2, 8'h03, 1'b0});
    qs.push_back('{8'd1, 8'h03, 1'b0}); qs.push_back('{8'd0, 8'h03, 1'b0});
    qs.push_back('{8'd2, 8'h03, 1'b0}); qs.push_back('{8'd1, 8'h03, 1'b0});
    qs.push_back('{8'd0, 8'h03, 1'b0}); qs.push_back('{8'd3, 8'h03, 1'b1});
    fork
      begin send_s(8'h1B, 0, 0); send_s(8'hC6, 1, 0); end
      begin
        @(posedge clk); @(negedge clk); stall = 1;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
          chk("stall_s_val", s_dv, 0); chk("stall_s_rdy", s_ur, 0);
          if (i == 2) stall = 0;
          @(posedge clk); #2;
        end
      end
    join
    repeat (4) @(posedge clk);
    #1 rnd = 1;
    fork rnd_p(); rnd_s(); rnd_d(); join
    rnd = 0;
    for (int t = 0; t < 1000 && (qp.size() + qs.size() + qd.size()) > 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_p", qp.size(), 0); chk("drain_s", qs.size(), 0); chk("drain_d", qd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
